// File: rtl/cpu_module_mem.sv
// -----------------------------------------------------------------------------
// cpu_module_mem
//
// MEM stage of the pipelined MIPS core, merged with the MEM/WB pipeline
// register. It runs a req/ack handshake with a variable-latency data memory,
// builds byte enables and replicated store lanes, and aligns and extends the
// returned load data. While an access is outstanding it stalls the upstream
// stages and injects bubbles into MEM/WB. An access that sees no ack for
// TIMEOUT BUSY cycles is aborted and reported as a bus error.
//
// Parameters
//   TIMEOUT        BUSY cycles without dmem_ack before abort (1..1023)
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   valid_mem .. LoadSigned_mem      EX/MEM fields of the instruction in MEM
//   dmem_req/we/addr/be/wdata        request side of the data-memory port
//   dmem_ack, dmem_rdata             response side (rdata valid with ack)
//   stall_mem                        hold PC, IF/ID, ID/EX and EX/MEM
//   valid_wb .. MemDout_wb           MEM/WB register for the write-back mux
//   AdErr_wb, BusErr_wb              one-cycle error pulses (misaligned, abort)
// -----------------------------------------------------------------------------
module cpu_module_mem #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // EX/MEM fields
  input  logic        valid_mem,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic        MemtoReg_mem,
  input  logic        RegWrite_mem,
  input  logic [4:0]  WriteReg_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] StoreData_mem,
  input  logic [1:0]  MemSize_mem,
  input  logic        LoadSigned_mem,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  // pipeline control
  output logic        stall_mem,
  // MEM/WB register
  output logic        valid_wb,
  output logic        RegWrite_wb,
  output logic        MemtoReg_wb,
  output logic [4:0]  WriteReg_wb,
  output logic [31:0] ALUResult_wb,
  output logic [31:0] MemDout_wb,
  output logic        AdErr_wb,
  output logic        BusErr_wb
);

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  // MemSize_mem encodings; 2'b11 falls through to word everywhere.
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state, state_next;
  logic [9:0]  cnt, cnt_next;

  logic        memop;
  logic        is_half;
  logic        is_byte;
  logic        is_word;
  logic        mis;
  logic        abort;
  logic        retire_valid;
  logic        load_retire;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  // ---------------------------------------------------------------------------
  // Access classification
  // ---------------------------------------------------------------------------
  assign memop   = valid_mem & (MemRead_mem | MemWrite_mem);
  assign is_half = (MemSize_mem == SIZE_HALF);
  assign is_byte = (MemSize_mem == SIZE_BYTE);
  assign is_word = ~is_half & ~is_byte;

  // Misaligned accesses are decided purely from the address; they never reach
  // the memory and never stall.
  assign mis = memop & ((is_half & ALUResult_mem[0]) |
                        (is_word & (ALUResult_mem[1:0] != 2'b00)));

  // Timeout abort is combinational so req and stall drop in the same cycle the
  // limit is reached; an ack in that very cycle still completes the access.
  assign abort = (state == BUSY) & (cnt == TIMEOUT_CNT) & ~dmem_ack;

  // ---------------------------------------------------------------------------
  // Request side. EX/MEM is frozen by stall_mem, so these stay stable for the
  // whole access without any local capture register.
  // ---------------------------------------------------------------------------
  assign dmem_req  = memop & ~mis & ~abort;
  assign dmem_we   = valid_mem & MemWrite_mem;
  assign dmem_addr = {ALUResult_mem[31:2], 2'b00};
  assign stall_mem = dmem_req & ~dmem_ack;

  // Store lanes are little-endian: lane 0 is bits [7:0]. Sub-word store data
  // is replicated across all lanes so the memory only has to honour dmem_be.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    dmem_be    = 4'b1111;
    dmem_wdata = StoreData_mem;
    if (MemWrite_mem) begin
      if (is_half) begin
        dmem_be    = 4'b0011 << {ALUResult_mem[1], 1'b0};
        dmem_wdata = {2{StoreData_mem[15:0]}};
      end else if (is_byte) begin
        dmem_be    = 4'b0001 << ALUResult_mem[1:0];
        dmem_wdata = {4{StoreData_mem[7:0]}};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  always_comb begin
    load_byte = dmem_rdata[{ALUResult_mem[1:0], 3'b000} +: 8];
    load_half = ALUResult_mem[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    if (is_half) begin
      load_data = {{16{LoadSigned_mem & load_half[15]}}, load_half};
    end else if (is_byte) begin
      load_data = {{24{LoadSigned_mem & load_byte[7]}}, load_byte};
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (dmem_req & ~dmem_ack) begin
          state_next = BUSY;
          cnt_next   = 10'd1;
        end
      end
      BUSY: begin
        // A dropped request covers the abort cycle, and also recovers if the
        // instruction ever disappears from MEM while we wait.
        if (dmem_ack | ~dmem_req) begin
          state_next = IDLE;
          cnt_next   = 10'd0;
        end else begin
          cnt_next = cnt + 10'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 10'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 10'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register
  // ---------------------------------------------------------------------------
  // With stall_mem low, any aligned memop in MEM has its ack this cycle (or
  // was aborted), so a retiring load always has valid dmem_rdata.
  assign retire_valid = valid_mem & ~mis & ~abort;
  assign load_retire  = retire_valid & MemRead_mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_wb     <= 1'b0;
      RegWrite_wb  <= 1'b0;
      MemtoReg_wb  <= 1'b0;
      WriteReg_wb  <= 5'd0;
      ALUResult_wb <= 32'd0;
      MemDout_wb   <= 32'd0;
      AdErr_wb     <= 1'b0;
      BusErr_wb    <= 1'b0;
    end else if (stall_mem) begin
      // Bubble into WB; the data fields are don't-care and simply hold.
      valid_wb    <= 1'b0;
      RegWrite_wb <= 1'b0;
      AdErr_wb    <= 1'b0;
      BusErr_wb   <= 1'b0;
    end else begin
      valid_wb     <= retire_valid;
      RegWrite_wb  <= RegWrite_mem & retire_valid;
      MemtoReg_wb  <= MemtoReg_mem;
      WriteReg_wb  <= WriteReg_mem;
      ALUResult_wb <= ALUResult_mem;
      AdErr_wb     <= mis;
      BusErr_wb    <= abort;
      if (load_retire) begin
        MemDout_wb <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_cpu_module_mem.sv
// -----------------------------------------------------------------------------
// tb_cpu_module_mem
//
// Directed and randomized bench for cpu_module_mem (TIMEOUT = 4). Each memory
// transaction is described by its fields plus the cycle in which the memory
// acknowledges; the expected stall length, error pulses, lanes and load value
// are derived from those at transaction level.
// -----------------------------------------------------------------------------
module tb_cpu_module_mem;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_mem = 1'b0;
  logic        MemRead_mem = 1'b0;
  logic        MemWrite_mem = 1'b0;
  logic        MemtoReg_mem = 1'b0;
  logic        RegWrite_mem = 1'b0;
  logic [4:0]  WriteReg_mem = '0;
  logic [31:0] ALUResult_mem = '0;
  logic [31:0] StoreData_mem = '0;
  logic [1:0]  MemSize_mem = '0;
  logic        LoadSigned_mem = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        stall_mem;
  logic        valid_wb;
  logic        RegWrite_wb;
  logic        MemtoReg_wb;
  logic [4:0]  WriteReg_wb;
  logic [31:0] ALUResult_wb;
  logic [31:0] MemDout_wb;
  logic        AdErr_wb;
  logic        BusErr_wb;

  cpu_module_mem #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_mem      (valid_mem),
    .MemRead_mem    (MemRead_mem),
    .MemWrite_mem   (MemWrite_mem),
    .MemtoReg_mem   (MemtoReg_mem),
    .RegWrite_mem   (RegWrite_mem),
    .WriteReg_mem   (WriteReg_mem),
    .ALUResult_mem  (ALUResult_mem),
    .StoreData_mem  (StoreData_mem),
    .MemSize_mem    (MemSize_mem),
    .LoadSigned_mem (LoadSigned_mem),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .stall_mem      (stall_mem),
    .valid_wb       (valid_wb),
    .RegWrite_wb    (RegWrite_wb),
    .MemtoReg_wb    (MemtoReg_wb),
    .WriteReg_wb    (WriteReg_wb),
    .ALUResult_wb   (ALUResult_wb),
    .MemDout_wb     (MemDout_wb),
    .AdErr_wb       (AdErr_wb),
    .BusErr_wb      (BusErr_wb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected MEM/WB contents that persist across transactions.
  logic [31:0] exp_alu  = '0;
  logic [31:0] exp_dout = '0;
  logic [4:0]  exp_wreg = '0;
  logic        exp_m2r  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: access width in bytes and lane arithmetic
  // ---------------------------------------------------------------------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b01) ? 2 : (size == 2'b10) ? 1 : 4;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] a);
    return (a % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic wr, input logic [1:0] size,
                                          input logic [31:0] a);
    logic [3:0] be;
    int off, n;
    if (!wr) return 4'hF;
    be  = '0;
    off = int'(a % 4);
    n   = nbytes(size);
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    int n;
    n = nbytes(size);
    w = '0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                             input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    int n;
    n = nbytes(size);
    if (n == 4) return rd;
    v    = rd >> (8 * int'(a % 4));
    mask = (32'd1 << (8 * n)) - 32'd1;
    v    = v & mask;
    if (sgn && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // One instruction through MEM. Called just after a falling edge; returns just
  // after a falling edge. lat = cycle (0 = request cycle) in which ack arrives.
  // ---------------------------------------------------------------------------
  task automatic run_txn(input string tag, input logic valid, input logic rd, input logic wr,
                         input logic m2r, input logic rw, input logic [4:0] wreg,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [1:0] size, input logic sgn, input int lat,
                         input logic [31:0] rdata);
    logic memop, mis, base_req, aborted, e_req, e_stall, vwb, done;
    valid_mem      = valid;
    MemRead_mem    = rd;
    MemWrite_mem   = wr;
    MemtoReg_mem   = m2r;
    RegWrite_mem   = rw;
    WriteReg_mem   = wreg;
    ALUResult_mem  = addr;
    StoreData_mem  = sdata;
    MemSize_mem    = size;
    LoadSigned_mem = sgn;
    memop    = valid & (rd | wr);
    mis      = memop & misaligned(size, addr);
    base_req = memop & ~mis;
    aborted  = base_req && (lat > TIMEOUT);
    done     = 1'b0;
    for (int c = 0; c <= TIMEOUT + 1; c++) begin
      dmem_ack   = (c == lat);
      dmem_rdata = (c == lat) ? rdata : $urandom();
      #1;
      e_req   = base_req && !(aborted && c == TIMEOUT);
      e_stall = e_req && (c != lat);
      check({tag, "_req"}, 32'(dmem_req), 32'(e_req));
      check({tag, "_stall"}, 32'(stall_mem), 32'(e_stall));
      if (c == 0 && base_req) begin
        check({tag, "_addr"}, dmem_addr, addr & ~32'd3);
        check({tag, "_we"}, 32'(dmem_we), 32'(wr));
        check({tag, "_be"}, 32'(dmem_be), 32'(model_be(wr, size, addr)));
        if (wr) check({tag, "_wdata"}, dmem_wdata, model_wdata(size, sdata));
      end
      @(posedge clk);
      #1;
      if (e_stall) begin
        check({tag, "_bub_valid"}, 32'(valid_wb), 32'd0);
        check({tag, "_bub_regwrite"}, 32'(RegWrite_wb), 32'd0);
        check({tag, "_bub_alu_hold"}, ALUResult_wb, exp_alu);
        check({tag, "_bub_err"}, {30'd0, AdErr_wb, BusErr_wb}, 32'd0);
      end else begin
        vwb      = valid & ~mis & ~aborted;
        exp_alu  = addr;
        exp_wreg = wreg;
        exp_m2r  = m2r;
        if (vwb && rd) exp_dout = model_load(size, sgn, addr, rdata);
        check({tag, "_valid_wb"}, 32'(valid_wb), 32'(vwb));
        check({tag, "_regwrite_wb"}, 32'(RegWrite_wb), 32'(rw & vwb));
        check({tag, "_memtoreg_wb"}, 32'(MemtoReg_wb), 32'(exp_m2r));
        check({tag, "_writereg_wb"}, 32'(WriteReg_wb), 32'(exp_wreg));
        check({tag, "_alu_wb"}, ALUResult_wb, exp_alu);
        check({tag, "_dout_wb"}, MemDout_wb, exp_dout);
        check({tag, "_aderr"}, 32'(AdErr_wb), 32'(mis));
        check({tag, "_buserr"}, 32'(BusErr_wb), 32'(aborted));
        done = 1'b1;
      end
      @(negedge clk);
      if (done) break;
    end
    if (!done) check({tag, "_never_retired"}, 32'(done), 32'd1);
    dmem_ack  = 1'b0;
    valid_mem = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_valid_wb", 32'(valid_wb), 32'd0);
    check("rst_regwrite_wb", 32'(RegWrite_wb), 32'd0);
    check("rst_alu_wb", ALUResult_wb, 32'd0);
    check("rst_dout_wb", MemDout_wb, 32'd0);
    check("rst_err", {30'd0, AdErr_wb, BusErr_wb}, 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed steps
    run_txn("alu_op", 1, 0, 0, 0, 1, 5'd5, 32'h1234, 32'h0, 2'b00, 0, 0, 32'h0);
    run_txn("lw_wait3", 1, 1, 0, 1, 1, 5'd8, 32'h100, 32'h0, 2'b00, 0, 3, 32'hDEADBEEF);
    check("lw_wait3_literal", MemDout_wb, 32'hDEADBEEF);
    run_txn("lb_signed", 1, 1, 0, 1, 1, 5'd9, 32'h103, 32'h0, 2'b10, 1, 0, 32'h80AABBCC);
    check("lb_signed_literal", MemDout_wb, 32'hFFFFFF80);
    run_txn("lbu", 1, 1, 0, 1, 1, 5'd9, 32'h103, 32'h0, 2'b10, 0, 0, 32'h80AABBCC);
    check("lbu_literal", MemDout_wb, 32'h00000080);
    run_txn("sh_102", 1, 0, 1, 0, 0, 5'd0, 32'h102, 32'h0000A5A5, 2'b01, 0, 1, 32'h0);
    run_txn("sb_101", 1, 0, 1, 0, 0, 5'd0, 32'h101, 32'h000000C3, 2'b10, 0, 0, 32'h0);
    run_txn("lw_mis", 1, 1, 0, 1, 1, 5'd3, 32'h102, 32'h0, 2'b00, 0, 0, 32'h0);
    run_txn("lw_timeout", 1, 1, 0, 1, 1, 5'd4, 32'h140, 32'h0, 2'b00, 0, 100, 32'h0);
    run_txn("lw_ack_at_limit", 1, 1, 0, 1, 1, 5'd4, 32'h144, 32'h0, 2'b00, 0, TIMEOUT,
            32'h13572468);

    // Reset in the middle of a BUSY wait
    valid_mem     = 1'b1;
    MemRead_mem   = 1'b1;
    MemWrite_mem  = 1'b0;
    MemSize_mem   = 2'b00;
    ALUResult_mem = 32'h200;
    dmem_ack      = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n     = 1'b0;
    valid_mem = 1'b0;
    #1;
    check("midbusy_rst_alu_wb", ALUResult_wb, 32'd0);
    check("midbusy_rst_dout_wb", MemDout_wb, 32'd0);
    check("midbusy_rst_writereg_wb", 32'(WriteReg_wb), 32'd0);
    check("midbusy_rst_stall", 32'(stall_mem), 32'd0);
    exp_alu  = '0;
    exp_dout = '0;
    exp_wreg = '0;
    exp_m2r  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // A stale wait counter would abort this access before its ack arrives.
    run_txn("post_rst_lw", 1, 1, 0, 1, 1, 5'd6, 32'h204, 32'h0, 2'b00, 0, TIMEOUT,
            32'hCAFEF00D);

    // Randomized traffic
    for (int k = 0; k < 80; k++) begin
      int kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 2));
      a    = $urandom();
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn($sformatf("rnd%0d", k), ($urandom_range(0, 9) != 0), kind == 1, kind == 2,
              1'($urandom()), 1'($urandom()), 5'($urandom()), a, $urandom(),
              2'($urandom()), 1'($urandom()), int'($urandom_range(0, 6)), $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
